core_plic: RTL and testbench
============================

Name: core_plic

Overview:
- Platform-level interrupt controller: arbitrates NUM_SRC level-sensitive external interrupt sources onto two hart contexts.
  - Context 0 (machine) drives the CSR file's m_ext_irq_i.
  - Context 1 (supervisor) drives s_ext_irq_i.
- Per-source priority, per-context enable and threshold, claim/complete handshake.
- Software programs it through a simple memory-mapped slave port on the core's peripheral bus.

Parameters:
- NUM_SRC, 8, number of sources; IDs 1..NUM_SRC; ID 0 reserved (means "none").
- PRIO_W, 3, priority width; priority 0 = never interrupts.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- irq_src_i  in  NUM_SRC  level interrupt lines, bit k-1 = source k, synchronous to clk_i
- req_i  in  1  bus request strobe
- we_i  in  1  1 = write, 0 = read
- addr_i  in  22  byte address (word aligned; addr_i[1:0] ignored)
- wdata_i  in  32  write data
- rdata_o  out  32  read data, valid with rvalid_o
- rvalid_o  out  1  response strobe, one cycle after every req_i (reads and writes)
- m_ext_irq_o  out  1  context 0 interrupt request
- s_ext_irq_o  out  1  context 1 interrupt request

Behaviour:
- Register map (unmapped reads return 0; unmapped writes ignored):
  - 0x000000+4*id: priority[id], PRIO_W bits, RW.
  - 0x001000: pending bitmap, RO (bit id).
  - 0x002000 / 0x002080: enable bitmap for ctx0 / ctx1, RW.
  - 0x200000 / 0x201000: threshold for ctx0 / ctx1, RW.
  - 0x200004 / 0x201004: claim (read) / complete (write) for ctx0 / ctx1.
  - Bit 0 of every bitmap and priority[0] are hardwired 0.
- Reset values: all priority, enable, threshold, pending and inflight state = 0; rdata_o=0, rvalid_o=0, both irq outputs = 0.
- Gateway, per source:
  - pending_d[id] is set when irq_src_i[id-1] & ~pending_q[id] & ~inflight_q[id].
  - Pending is cleared only by a claim.
  - Source level is sampled each cycle; deassertion before claim does not clear pending.
- Selection, per context c:
  - Candidate = pending_q & enable_c & (priority > threshold_c).
  - Winner = highest priority; ties go to the lowest ID.
  - Winner ID = 0 if there is no candidate.
- IRQ outputs: registered; irq_c_q <= (winner_c != 0). Latency is one cycle from pending/enable/priority/threshold change to output.
- Claim read:
  - rdata_o = winner_c, evaluated on register state in the req_i cycle.
  - Next cycle: pending[winner] cleared, inflight[winner] set.
  - A claim with winner 0 returns 0 and changes nothing.
- Complete write:
  - wdata_i[ID] with 1 <= ID <= NUM_SRC clears inflight[ID]; out-of-range IDs are ignored.
  - Completing a non-inflight ID is a no-op.
- Simultaneous events:
  - Complete and a still-high source in the same cycle: pending re-sets in the cycle after inflight clears (two cycles after the write).
  - Source assert in the same cycle as a claim of another ID: both take effect independently.
- Bus responses:
  - Single outstanding request: rvalid_o pulses exactly one cycle after req_i, with rdata_o registered.
  - Back-to-back requests are allowed, one per cycle.
  - rdata_o returns 0 on writes.
- Reset mid-operation (async assert): all state clears immediately and outputs drop in the same instant. The first cycle after deassertion behaves as post-reset.

Decomposition:
- core_defs package gets:
  - PLIC base offsets (PRIO, PENDING, ENABLE, CTX stride 0x80/0x1000, THRESHOLD, CLAIM) as localparams.
  - A plic_ctx_e enum (PLIC_CTX_M=0, PLIC_CTX_S=1).
- One sub-module, core_plic_sel: combinational max-priority/lowest-ID reduction over NUM_SRC candidates, returning id and priority. Instantiated once per context.

Test Plan:
- Reset → all reads 0, m_ext_irq_o=s_ext_irq_o=0, rvalid_o=0.
- Setup: prio[3]=2, enable ctx0=0x08, threshold0=1.
  - Pulse src3 high for 1 cycle → pending=0x08, m_ext_irq_o=1 next cycle.
  - Claim0 returns 3; pending=0, irq drops next cycle.
  - Complete 3 → inflight cleared.
- Src2 and src5 both high, prio[2]=prio[5]=4, both enabled ctx0 → claim returns 2; a second claim returns 5.
- prio[4]=3, threshold1=3, enable ctx1=0x10, src4 high → s_ext_irq_o stays 0. Write threshold1=2 → s_ext_irq_o=1 one cycle later; m_ext_irq_o stays 0.
- Src6 held high, claimed (returns 6) → pending stays 0 while inflight. Complete 6 → pending[6]=1 two cycles after the write; complete 9 with NUM_SRC=8 is ignored.
- Assert rst_ni low mid-claim with irq outputs high → outputs 0 asynchronously; all registers read 0 after release.

Source files
------------

// File: rtl/core_defs_pkg.sv
// rtl/core_defs_pkg.sv - PLIC register map offsets and context type
package core_defs;

  localparam logic [21:0] PLIC_PRIO_BASE     = 22'h000000;
  localparam logic [21:0] PLIC_PENDING       = 22'h001000;
  localparam logic [21:0] PLIC_ENABLE_BASE   = 22'h002000;
  localparam logic [21:0] PLIC_ENABLE_STRIDE = 22'h000080;
  localparam logic [21:0] PLIC_CTX_BASE      = 22'h200000;
  localparam logic [21:0] PLIC_CTX_STRIDE    = 22'h001000;
  localparam logic [21:0] PLIC_THRESHOLD     = 22'h000000;
  localparam logic [21:0] PLIC_CLAIM         = 22'h000004;

  typedef enum logic [0:0] {
    PLIC_CTX_M = 1'b0,
    PLIC_CTX_S = 1'b1
  } plic_ctx_e;

  function automatic logic [21:0] plic_enable_addr(plic_ctx_e ctx);
    return PLIC_ENABLE_BASE + ((ctx == PLIC_CTX_S) ? PLIC_ENABLE_STRIDE : 22'h0);
  endfunction

  function automatic logic [21:0] plic_ctx_addr(plic_ctx_e ctx, logic [21:0] ofs);
    return PLIC_CTX_BASE + ((ctx == PLIC_CTX_S) ? PLIC_CTX_STRIDE : 22'h0) + ofs;
  endfunction

endpackage

// File: rtl/core_plic_sel.sv
// rtl/core_plic_sel.sv - max-priority / lowest-ID winner over pending candidates
module core_plic_sel #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
  input  logic [NUM_SRC:0]             cand_i,
  input  logic [NUM_SRC:0][PRIO_W-1:0] prio_i,
  output logic [ID_W-1:0]              id_o,
  output logic [PRIO_W-1:0]            prio_o
);

  logic w_unused;
  assign w_unused = cand_i[0] ^ (^prio_i[0]);

  // Strict '>' keeps the earlier (lower) ID on a priority tie.
  always_comb begin
    id_o   = '0;
    prio_o = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (cand_i[k] && (prio_i[k] > prio_o)) begin
        id_o   = ID_W'(k);
        prio_o = prio_i[k];
      end
    end
  end

endmodule

// File: rtl/core_plic.sv
// rtl/core_plic.sv - two-context platform interrupt controller with claim/complete
module core_plic
  import core_defs::*;
#(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [21:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               rvalid_o,
  output logic               m_ext_irq_o,
  output logic               s_ext_irq_o
);

  localparam int ID_W = $clog2(NUM_SRC + 1);

  logic [NUM_SRC:0][PRIO_W-1:0] r_prio;
  logic [NUM_SRC:0]             r_pending;
  logic [NUM_SRC:0]             r_inflight;
  logic [1:0][NUM_SRC:0]        r_enable;
  logic [1:0][PRIO_W-1:0]       r_thresh;
  logic [1:0]                   r_irq;
  logic [31:0]                  r_rdata;
  logic                         r_rvalid;

  logic [21:0]                  w_addr;
  logic                         w_wr;
  logic                         w_rd;
  logic                         w_pend_hit;
  logic [NUM_SRC:0]             w_prio_hit;
  logic [1:0]                   w_en_hit;
  logic [1:0]                   w_th_hit;
  logic [1:0]                   w_cl_hit;
  logic [1:0][ID_W-1:0]         w_win_id;
  logic [1:0][PRIO_W-1:0]       w_win_prio;
  logic                         w_cpl_ok;
  logic [ID_W-1:0]              w_cpl_id;
  logic [NUM_SRC:0]             w_src;
  logic [NUM_SRC:0]             w_pending_d;
  logic [NUM_SRC:0]             w_inflight_d;
  logic [31:0]                  w_rdata;
  logic                         w_unused;

  assign w_addr     = {addr_i[21:2], 2'b00};
  assign w_wr       = req_i & we_i;
  assign w_rd       = req_i & ~we_i;
  assign w_pend_hit = (w_addr == PLIC_PENDING);
  assign w_cpl_ok   = (wdata_i != 32'd0) && (wdata_i <= 32'(NUM_SRC));
  assign w_cpl_id   = wdata_i[ID_W-1:0];
  assign w_src      = {irq_src_i, 1'b0};
  assign w_unused   = ^{addr_i[1:0], w_win_prio};

  for (genvar k = 0; k <= NUM_SRC; k++) begin : g_prio_hit
    if (k == 0) begin : g_zero
      assign w_prio_hit[k] = 1'b0;
    end else begin : g_src
      assign w_prio_hit[k] = (w_addr == PLIC_PRIO_BASE + 22'(4 * k));
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_ctx
    localparam plic_ctx_e CTX = (c == 0) ? PLIC_CTX_M : PLIC_CTX_S;
    logic [NUM_SRC:0] w_cand;

    assign w_en_hit[c] = (w_addr == plic_enable_addr(CTX));
    assign w_th_hit[c] = (w_addr == plic_ctx_addr(CTX, PLIC_THRESHOLD));
    assign w_cl_hit[c] = (w_addr == plic_ctx_addr(CTX, PLIC_CLAIM));

    for (genvar k = 0; k <= NUM_SRC; k++) begin : g_cand
      assign w_cand[k] = r_pending[k] & r_enable[c][k] & (r_prio[k] > r_thresh[c]);
    end

    core_plic_sel #(
      .NUM_SRC (NUM_SRC),
      .PRIO_W  (PRIO_W),
      .ID_W    (ID_W)
    ) u_sel (
      .cand_i (w_cand),
      .prio_i (r_prio),
      .id_o   (w_win_id[c]),
      .prio_o (w_win_prio[c])
    );
  end

  always_comb begin
    w_rdata = '0;
    if (w_pend_hit) w_rdata[NUM_SRC:0] = r_pending;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (w_prio_hit[k]) w_rdata[PRIO_W-1:0] = r_prio[k];
    end
    for (int c = 0; c < 2; c++) begin
      if (w_en_hit[c]) w_rdata[NUM_SRC:0]  = r_enable[c];
      if (w_th_hit[c]) w_rdata[PRIO_W-1:0] = r_thresh[c];
      if (w_cl_hit[c]) w_rdata[ID_W-1:0]   = w_win_id[c];
    end
  end

  // Gateway: a source re-arms only once it is neither pending nor in service.
  always_comb begin
    w_pending_d  = r_pending | (w_src & ~r_pending & ~r_inflight);
    w_inflight_d = r_inflight;
    for (int c = 0; c < 2; c++) begin
      if (w_wr && w_cl_hit[c] && w_cpl_ok) w_inflight_d[w_cpl_id] = 1'b0;
      if (w_rd && w_cl_hit[c] && (w_win_id[c] != '0)) begin
        w_pending_d[w_win_id[c]]  = 1'b0;
        w_inflight_d[w_win_id[c]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prio     <= '0;
      r_pending  <= '0;
      r_inflight <= '0;
      r_enable   <= '0;
      r_thresh   <= '0;
      r_irq      <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      r_rvalid   <= req_i;
      r_rdata    <= w_rd ? w_rdata : 32'd0;
      r_pending  <= w_pending_d;
      r_inflight <= w_inflight_d;
      for (int c = 0; c < 2; c++) begin
        r_irq[c] <= (w_win_id[c] != '0);
        if (w_wr && w_en_hit[c]) r_enable[c] <= {wdata_i[NUM_SRC:1], 1'b0};
        if (w_wr && w_th_hit[c]) r_thresh[c] <= wdata_i[PRIO_W-1:0];
      end
      for (int k = 1; k <= NUM_SRC; k++) begin
        if (w_wr && w_prio_hit[k]) r_prio[k] <= wdata_i[PRIO_W-1:0];
      end
    end
  end

  assign rdata_o     = r_rdata;
  assign rvalid_o    = r_rvalid;
  assign m_ext_irq_o = r_irq[0];
  assign s_ext_irq_o = r_irq[1];

endmodule

// File: tb/tb_core_plic.sv
// tb/tb_core_plic.sv - directed self-checking bench for core_plic
module tb_core_plic;

  logic        clk_i;
  logic        rst_ni;
  logic [7:0]  irq_src_i;
  logic        req_i;
  logic        we_i;
  logic [21:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        m_ext_irq_o;
  logic        s_ext_irq_o;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [21:0] A_PEND  = 22'h001000;
  localparam logic [21:0] A_EN0   = 22'h002000;
  localparam logic [21:0] A_EN1   = 22'h002080;
  localparam logic [21:0] A_TH0   = 22'h200000;
  localparam logic [21:0] A_TH1   = 22'h201000;
  localparam logic [21:0] A_CL0   = 22'h200004;
  localparam logic [21:0] A_CL1   = 22'h201004;

  core_plic #(.NUM_SRC(8), .PRIO_W(3)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .irq_src_i   (irq_src_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o),
    .m_ext_irq_o (m_ext_irq_o),
    .s_ext_irq_o (s_ext_irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [21:0] a, input logic [31:0] d,
                     output logic [31:0] rd);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = a;
    wdata_i = d;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0;
    we_i  = 1'b0;
    chk("rvalid", {31'b0, rvalid_o}, 32'd1);
    rd = rdata_o;
  endtask

  task automatic wr(input logic [21:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bus(1'b1, a, d, rd);
    chk("wr_rdata", rd, 32'd0);
  endtask

  task automatic rdc(input string tag, input logic [21:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bus(1'b0, a, 32'd0, rd);
    chk(tag, rd, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    rst_ni    = 1'b0;
    irq_src_i = '0;
    req_i     = 1'b0;
    we_i      = 1'b0;
    addr_i    = '0;
    wdata_i   = '0;
    #1;
    chk("rst_m_irq", {31'b0, m_ext_irq_o}, 32'd0);
    chk("rst_s_irq", {31'b0, s_ext_irq_o}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    cyc(2);
    rst_ni = 1'b1;
    cyc(1);

    rdc("rst_pend", A_PEND, 32'd0);
    rdc("rst_prio3", 22'h00000c, 32'd0);
    rdc("rst_en0", A_EN0, 32'd0);
    rdc("rst_th0", A_TH0, 32'd0);
    rdc("rst_claim0", A_CL0, 32'd0);
    cyc(1);
    chk("idle_rvalid", {31'b0, rvalid_o}, 32'd0);

    // basic setup, hardwired bit 0 / priority[0], unmapped read
    wr(22'h00000c, 32'd2);
    wr(A_EN0, 32'h09);
    wr(A_TH0, 32'd1);
    wr(22'h000000, 32'd7);
    rdc("prio3", 22'h00000c, 32'd2);
    rdc("en0_bit0", A_EN0, 32'h08);
    rdc("prio0", 22'h000000, 32'd0);
    rdc("unmapped", 22'h003000, 32'd0);

    // single pulse on source 3
    irq_src_i = 8'b0000_0100;
    cyc(1);
    irq_src_i = '0;
    chk("m_irq_latency", {31'b0, m_ext_irq_o}, 32'd0);
    rdc("pend_src3", A_PEND, 32'h08);
    chk("m_irq_src3", {31'b0, m_ext_irq_o}, 32'd1);
    rdc("claim_3", A_CL0, 32'd3);
    chk("m_irq_hold", {31'b0, m_ext_irq_o}, 32'd1);
    rdc("claim_none", A_CL0, 32'd0);
    chk("m_irq_drop", {31'b0, m_ext_irq_o}, 32'd0);
    rdc("pend_claimed", A_PEND, 32'd0);

    // inflight blocks re-pending until complete
    irq_src_i = 8'b0000_0100;
    cyc(1);
    irq_src_i = '0;
    rdc("pend_inflight3", A_PEND, 32'd0);
    wr(A_CL0, 32'd3);
    irq_src_i = 8'b0000_0100;
    cyc(1);
    irq_src_i = '0;
    rdc("pend_after_cpl3", A_PEND, 32'h08);
    rdc("claim_3b", A_CL0, 32'd3);
    wr(A_CL0, 32'd3);

    // tie on priority: lowest ID first
    wr(22'h000008, 32'd4);
    wr(22'h000014, 32'd4);
    wr(A_EN0, 32'h24);
    irq_src_i = 8'b0001_0010;
    cyc(1);
    irq_src_i = '0;
    rdc("pend_2_5", A_PEND, 32'h24);
    rdc("claim_tie_2", A_CL0, 32'd2);
    rdc("claim_tie_5", A_CL0, 32'd5);
    rdc("claim_tie_none", A_CL0, 32'd0);
    wr(A_CL0, 32'd2);
    wr(A_CL0, 32'd5);

    // context 1 threshold boundary
    wr(22'h000010, 32'd3);
    wr(A_TH1, 32'd3);
    wr(A_EN1, 32'h10);
    irq_src_i = 8'b0000_1000;
    cyc(2);
    chk("s_irq_eq_thresh", {31'b0, s_ext_irq_o}, 32'd0);
    wr(A_TH1, 32'd2);
    chk("s_irq_thresh_lat", {31'b0, s_ext_irq_o}, 32'd0);
    cyc(1);
    chk("s_irq_below_thresh", {31'b0, s_ext_irq_o}, 32'd1);
    chk("m_irq_not_en", {31'b0, m_ext_irq_o}, 32'd0);
    irq_src_i = '0;
    cyc(1);
    rdc("pend_level_drop", A_PEND, 32'h10);
    rdc("claim1_4", A_CL1, 32'd4);
    wr(A_CL1, 32'd4);

    // held source: pending re-sets two cycles after complete
    wr(22'h000018, 32'd5);
    wr(A_EN0, 32'h40);
    irq_src_i = 8'b0010_0000;
    cyc(2);
    rdc("claim_6", A_CL0, 32'd6);
    rdc("pend_held_inflight", A_PEND, 32'd0);
    wr(A_CL0, 32'd9);
    rdc("pend_cpl9_ignored", A_PEND, 32'd0);
    chk("m_irq_inflight", {31'b0, m_ext_irq_o}, 32'd0);
    wr(A_CL0, 32'd6);
    rdc("pend_1cyc", A_PEND, 32'd0);
    rdc("pend_2cyc", A_PEND, 32'h40);
    chk("m_irq_repend", {31'b0, m_ext_irq_o}, 32'd1);

    // asynchronous reset in the middle of a claim
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = A_CL0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_m_irq", {31'b0, m_ext_irq_o}, 32'd0);
    chk("arst_s_irq", {31'b0, s_ext_irq_o}, 32'd0);
    chk("arst_rvalid", {31'b0, rvalid_o}, 32'd0);
    req_i     = 1'b0;
    irq_src_i = '0;
    cyc(2);
    rst_ni = 1'b1;
    cyc(1);
    rdc("post_prio3", 22'h00000c, 32'd0);
    rdc("post_prio6", 22'h000018, 32'd0);
    rdc("post_en0", A_EN0, 32'd0);
    rdc("post_en1", A_EN1, 32'd0);
    rdc("post_th0", A_TH0, 32'd0);
    rdc("post_th1", A_TH1, 32'd0);
    rdc("post_pend", A_PEND, 32'd0);
    rdc("post_claim0", A_CL0, 32'd0);
    chk("post_m_irq", {31'b0, m_ext_irq_o}, 32'd0);
    chk("post_s_irq", {31'b0, s_ext_irq_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
